// File: rtl/hex_display_scan_ctrl.sv
// hex_display_scan_ctrl: multiplexes one shared hex decoder across NUM_DIGITS digits,
// with a double-buffered load port so a new value only appears at a frame boundary.
module hex_display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    display_on,
    output logic [3:0]              hex_out,
    output logic                    dec_enable,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx, next_idx;
    logic [DW-1:0]         active, shadow, next_active;
    logic                  pending, tick, boundary, accept, nz;
    logic [NUM_DIGITS-1:0] blank;

    assign tick        = cnt == CW'(PRESCALE - 1);
    assign boundary    = tick && idx == IW'(NUM_DIGITS - 1);
    assign next_idx    = !tick ? idx : boundary ? '0 : idx + 1'b1;
    assign next_active = boundary && pending ? shadow : active;
    assign accept      = load_valid && !pending;
    assign load_ready  = !pending;

    // A digit is dark when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        blank = '0;
        nz    = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            nz       = nz | (next_active[4*i +: 4] != 4'h0);
            blank[i] = LZ_BLANK && !nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            hex_out    <= 4'h0;
            digit_sel  <= '1;
            dec_enable <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            idx        <= next_idx;
            active     <= next_active;
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            hex_out    <= next_active[4*next_idx +: 4];
            digit_sel  <= blank[next_idx] ? '1 : ~(NUM_DIGITS'(1) << next_idx);
            dec_enable <= display_on;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// tb_hex_display_scan_ctrl: scenario tasks plus a cycle scoreboard for the scan controller,
// run on a blanking and a non-blanking instance sharing the same stimulus.
module tb_hex_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        display_on = 1'b1;
    logic        load_ready, dec_enable, frame_done;
    logic [3:0]  hex_out, digit_sel;
    logic        load_ready0, dec_enable0, frame_done0;
    logic [3:0]  hex_out0, digit_sel0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0] hex, sel1, sel0;
        logic       en, fd, rdy;
    } exp_t;
    exp_t sbq[$];

    int          m_cnt, m_idx, nidx;
    logic [15:0] m_act, m_sh, nact, top;
    logic        m_pend, bnd, acc;

    always #5 clk = ~clk;

    hex_display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .display_on(display_on), .hex_out(hex_out),
        .dec_enable(dec_enable), .digit_sel(digit_sel), .frame_done(frame_done));

    hex_display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .display_on(display_on), .hex_out(hex_out0),
        .dec_enable(dec_enable0), .digit_sel(digit_sel0), .frame_done(frame_done0));

    // Reference model: predicts the outputs each edge should produce and queues them.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_act = 16'h0; m_sh = 16'h0; m_pend = 1'b0;
            e.hex = 4'h0; e.sel1 = 4'hF; e.sel0 = 4'hF; e.en = 1'b0; e.fd = 1'b0; e.rdy = 1'b1;
        end else begin
            bnd  = m_cnt == 3 && m_idx == 3;
            nidx = m_cnt == 3 ? (m_idx + 1) % 4 : m_idx;
            nact = bnd && m_pend ? m_sh : m_act;
            acc  = load_valid && !m_pend;
            if (bnd && m_pend) m_pend = 1'b0;
            if (acc) begin m_sh = load_data; m_pend = 1'b1; end
            m_cnt = m_cnt == 3 ? 0 : m_cnt + 1;
            m_idx = nidx;
            m_act = nact;
            top    = nact >> (4 * nidx);
            e.hex  = top[3:0];
            e.sel0 = ~(4'b0001 << nidx);
            e.sel1 = (nidx != 0 && top == 16'h0) ? 4'hF : e.sel0;
            e.en   = display_on;
            e.fd   = bnd;
            e.rdy  = !m_pend;
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({hex_out, digit_sel, dec_enable, frame_done, load_ready} !== {e.hex, e.sel1, e.en, e.fd, e.rdy}) begin
                errors++;
                $display("FAIL sb_lz1 t=%0t: hex=%h sel=%b en=%b fd=%b rdy=%b, expected hex=%h sel=%b en=%b fd=%b rdy=%b",
                         $time, hex_out, digit_sel, dec_enable, frame_done, load_ready, e.hex, e.sel1, e.en, e.fd, e.rdy);
            end
            checks++;
            if ({hex_out0, digit_sel0, dec_enable0, frame_done0, load_ready0} !== {e.hex, e.sel0, e.en, e.fd, e.rdy}) begin
                errors++;
                $display("FAIL sb_lz0 t=%0t: hex=%h sel=%b en=%b fd=%b rdy=%b, expected hex=%h sel=%b en=%b fd=%b rdy=%b",
                         $time, hex_out0, digit_sel0, dec_enable0, frame_done0, load_ready0, e.hex, e.sel0, e.en, e.fd, e.rdy);
            end
        end
    end

    task automatic sync_frame;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL sync_frame: frame_done=%b after %0d cycles, expected 1", frame_done, n);
        end
    endtask

    task automatic test_reset;
        int n = 0, bad = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({hex_out, digit_sel, dec_enable, frame_done, load_ready} !== {4'h0, 4'hF, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: hex=%h sel=%b en=%b fd=%b rdy=%b, expected 0 1111 0 0 1",
                     hex_out, digit_sel, dec_enable, frame_done, load_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({digit_sel, dec_enable} !== {4'hE, 1'b1}) begin
            errors++;
            $display("FAIL reset_exit: sel=%b en=%b, expected 1110 1", digit_sel, dec_enable);
        end
        sync_frame();
        do begin
            if (digit_sel !== (n < 4 ? 4'hE : 4'hF)) bad++;
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL frame_period: %0d cycles, expected 16", n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_blank: %0d cycles with wrong digit_sel, expected 0", bad);
        end
    endtask

    task automatic test_load_transfer;
        logic [3:0] hx [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
        logic [3:0] sl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        int n = 0, bad = 0;
        repeat (2) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h1A3F;
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'h0;
        while (!frame_done && n < 40) begin
            if (load_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bad != 0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: %0d cycles ready high, fd=%b, expected 0 and 1", bad, frame_done);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return: load_ready=%b, expected 1", load_ready);
        end
        for (int c = 0; c < 16; c++) begin
            checks++;
            if ({hex_out, digit_sel} !== {hx[c/4], sl[c/4]}) begin
                errors++;
                $display("FAIL transfer_seq[%0d]: hex=%h sel=%b, expected hex=%h sel=%b", c, hex_out, digit_sel, hx[c/4], sl[c/4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank;
        logic [3:0] hx [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
        logic [3:0] s1 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
        logic [3:0] s0 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        repeat (2) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h0050;
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'h0;
        sync_frame();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if ({hex_out, digit_sel, digit_sel0} !== {hx[c/4], s1[c/4], s0[c/4]}) begin
                errors++;
                $display("FAIL blank_seq[%0d]: hex=%h sel_lz1=%b sel_lz0=%b, expected %h %b %b",
                         c, hex_out, digit_sel, digit_sel0, hx[c/4], s1[c/4], s0[c/4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0, bad = 0;
        repeat (2) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h1111;
        @(negedge clk);
        load_data = 16'h2222;
        while (!frame_done && n < 40) begin
            if (load_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bad != 0 || {hex_out, load_ready} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL backpressure: ready_high=%0d hex=%h rdy=%b, expected 0 1 1", bad, hex_out, load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'h0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_accept: load_ready=%b, expected 0", load_ready);
        end
        bad = 0;
        repeat (14) begin
            @(negedge clk);
            if (hex_out !== 4'h1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_1111: %0d cycles hex not 1, expected 0", bad);
        end
        sync_frame();
        checks++;
        if ({hex_out, digit_sel} !== {4'h2, 4'hE}) begin
            errors++;
            $display("FAIL show_2222: hex=%h sel=%b, expected 2 1110", hex_out, digit_sel);
        end
        repeat (15) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h4C5D;
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'h0;
        checks++;
        if ({frame_done, hex_out, load_ready} !== {1'b1, 4'h2, 1'b0}) begin
            errors++;
            $display("FAIL boundary_load: fd=%b hex=%h rdy=%b, expected 1 2 0", frame_done, hex_out, load_ready);
        end
        sync_frame();
        checks++;
        if ({hex_out, load_ready} !== {4'hD, 1'b1}) begin
            errors++;
            $display("FAIL boundary_load_late: hex=%h rdy=%b, expected d 1", hex_out, load_ready);
        end
    endtask

    task automatic test_display_on;
        int bad = 0;
        @(negedge clk);
        display_on = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dec_enable !== 1'b0 || dec_enable0 !== 1'b0) bad++;
        end
        display_on = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL display_off: %0d cycles enabled, expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (dec_enable !== 1'b1) begin
            errors++;
            $display("FAIL display_on: dec_enable=%b, expected 1", dec_enable);
        end
    endtask

    task automatic test_reset_mid;
        sync_frame();
        repeat (2) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h1234;
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'h0;
        repeat (6) @(negedge clk);
        checks++;
        if ({load_ready, digit_sel} !== {1'b0, 4'hB}) begin
            errors++;
            $display("FAIL pre_reset: rdy=%b sel=%b, expected 0 1011", load_ready, digit_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({hex_out, digit_sel, dec_enable, frame_done, load_ready} !== {4'h0, 4'hF, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: hex=%h sel=%b en=%b fd=%b rdy=%b, expected 0 1111 0 0 1",
                     hex_out, digit_sel, dec_enable, frame_done, load_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({hex_out, digit_sel, dec_enable} !== {4'h0, 4'hE, 1'b1}) begin
            errors++;
            $display("FAIL restart: hex=%h sel=%b en=%b, expected 0 1110 1", hex_out, digit_sel, dec_enable);
        end
        sync_frame();
        checks++;
        if ({hex_out, digit_sel} !== {4'h0, 4'hE}) begin
            errors++;
            $display("FAIL data_lost: hex=%h sel=%b, expected 0 1110", hex_out, digit_sel);
        end
    endtask

    initial begin
        test_reset();
        test_load_transfer();
        test_blank();
        test_back_to_back();
        test_display_on();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
